alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
ID/EX issue stage that sits on the producing side of the ALU interface. It decodes ALU operation fields into the 4-bit ALU control code and registers the operands and control into the ID/EX pipeline register. It then forwards EX/MEM and MEM/WB results onto the ALU A/B inputs. Stall holds the stage and flush inserts a bubble, so the ALU always sees a coherent operation.

Parameters:
XLEN, 32, datapath width of operands, immediate and results
REG_ADDR_W, 5, register index width

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
id_valid  in  1  ID stage holds a real instruction
stall  in  1  hold the ID/EX register contents (hazard unit)
flush  in  1  load a bubble into ID/EX (branch taken / exception)
id_alu_op  in  2  00 mem-address add, 01 branch compare, 10 R-type, 11 reserved
id_funct3  in  3  instruction funct3
id_funct7b5  in  1  instruction bit 30
id_alu_src  in  1  1 selects the immediate for operand B
id_reg_write  in  1  instruction writes rd
id_rs1, id_rs2, id_rd  in  REG_ADDR_W each  register indices
id_rs1_data, id_rs2_data, id_imm  in  XLEN each  register-file reads and sign-extended immediate
exmem_reg_write  in  1; exmem_rd  in  REG_ADDR_W; exmem_result  in  XLEN  EX/MEM writeback source
memwb_reg_write  in  1; memwb_rd  in  REG_ADDR_W; memwb_result  in  XLEN  MEM/WB writeback source
ex_valid  out  1  EX holds a real instruction
alu_a, alu_b  out  XLEN  ALU operands (registered value after the forwarding mux)
alu_control  out  4  ALU control code (registered)
ex_store_data  out  XLEN  forwarded rs2 value for stores
ex_rd  out  REG_ADDR_W; ex_reg_write  out  1  destination info passed down the pipe
ex_is_branch  out  1  registered (id_alu_op==01); the consumer uses the ALU zero flag
ex_illegal  out  1  undecodable ALU op captured
fwd_a, fwd_b  out  2  forwarding select: 00 register, 10 EX/MEM, 01 MEM/WB

Behaviour:
- Decode (combinational in ID, registered into EX):
  - alu_op 00 -> 0010 (ADD).
  - alu_op 01 -> 0110 (SUB).
  - alu_op 10 R-type: funct3 000 with b5=0 -> 0010 ADD; funct3 000 with b5=1 -> 0110 SUB; funct3 111 -> 0000 AND; funct3 110 -> 0001 OR.
  - Any other funct3 with alu_op 10, or alu_op 11 -> code 0010, illegal=1, reg_write forced 0.
- Register update priority on each rising edge: reset > flush > stall > load.
  - reset or flush: bubble. valid=0, alu_control=0010, reg_write=0, rd=0, rs1=rs2=0, is_branch=0, illegal=0, data fields=0.
  - stall (no flush): all fields hold.
  - Otherwise: load the ID fields, with valid=id_valid. When id_valid=0, reg_write, is_branch and illegal load 0.
- Reset values of outputs: ex_valid=0, alu_control=0010, ex_reg_write=0, ex_rd=0, ex_is_branch=0, ex_illegal=0, fwd_a=fwd_b=00, alu_a=alu_b=ex_store_data=0.
- Forwarding (combinational from registered rs1/rs2 and the current writeback ports):
  - A source: EX/MEM if exmem_reg_write && exmem_rd!=0 && exmem_rd==rs1. Otherwise MEM/WB under the same test. Otherwise the registered rs1_data. EX/MEM wins when both match.
  - B source: same rules on rs2. ex_store_data = forwarded rs2 value.
  - alu_b = alu_src ? imm : forwarded rs2. fwd_b still reports the rs2 selection when alu_src=1.
  - Register x0 is never forwarded.
- Latency: one cycle from ID capture to alu_control/alu_a/alu_b. Forwarding adds no cycle.
- During a stall, forwarding keeps re-evaluating against the live EX/MEM and MEM/WB ports, so a held instruction picks up newly produced values.
- Simultaneous flush and stall: flush wins and a bubble is loaded.
- Reset mid-stall: bubble.

Test Plan:
- Reset asserted 2 cycles, then released with id_valid=0 -> ex_valid=0, alu_control=0010, ex_reg_write=0, all data outputs 0.
- R-type funct3=000, b5=1, rs1_data=9, rs2_data=4, no hazards -> next cycle alu_control=0110, alu_a=9, alu_b=4, fwd_a=fwd_b=00.
- Captured rs1=5, with exmem_rd=5 result=0x11 and memwb_rd=5 result=0x22, both reg_write=1 -> alu_a=0x11, fwd_a=10. Drop exmem_reg_write -> alu_a=0x22, fwd_a=01.
- Captured rs2=0, with exmem_rd=0 result=0xFF and reg_write=1 -> no forward: fwd_b=00, alu_b=rs2_data.
- Load an AND instruction, hold stall for 3 cycles while changing ID inputs -> alu_control stays 0000 and operands unchanged. Assert stall+flush together -> ex_valid=0, alu_control=0010.
- alu_op=10 with funct3=010 -> ex_illegal=1, alu_control=0010, ex_reg_write=0. alu_op=01 -> ex_is_branch=1, alu_control=0110; rs1_data=rs2_data=7 -> alu_a and alu_b both 7.

Source files
------------

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: ALU decode, ID/EX register and operand forwarding.
// Drives registered control and forwarded operands into the EX-stage ALU.
module alu_issue_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [1:0]            id_alu_op,
  input  logic [2:0]            id_funct3,
  input  logic                  id_funct7b5,
  input  logic                  id_alu_src,
  input  logic                  id_reg_write,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [XLEN-1:0]       id_rs1_data,
  input  logic [XLEN-1:0]       id_rs2_data,
  input  logic [XLEN-1:0]       id_imm,
  input  logic                  exmem_reg_write,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic [XLEN-1:0]       exmem_result,
  input  logic                  memwb_reg_write,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic [XLEN-1:0]       memwb_result,
  output logic                  ex_valid,
  output logic [XLEN-1:0]       alu_a,
  output logic [XLEN-1:0]       alu_b,
  output logic [3:0]            alu_control,
  output logic [XLEN-1:0]       ex_store_data,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_reg_write,
  output logic                  ex_is_branch,
  output logic                  ex_illegal,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b
);

  localparam logic [3:0] CtlAnd = 4'b0000;
  localparam logic [3:0] CtlOr  = 4'b0001;
  localparam logic [3:0] CtlAdd = 4'b0010;
  localparam logic [3:0] CtlSub = 4'b0110;

  localparam logic [1:0] FwdReg = 2'b00;
  localparam logic [1:0] FwdMem = 2'b10;
  localparam logic [1:0] FwdWb  = 2'b01;

  typedef struct packed {
    logic                  valid;
    logic [3:0]            ctrl;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [XLEN-1:0]       rs1_data;
    logic [XLEN-1:0]       rs2_data;
    logic [XLEN-1:0]       imm;
    logic                  alu_src;
    logic                  is_branch;
    logic                  illegal;
  } id_ex_t;

  id_ex_t ex_q, ex_d, load, bubble;
  logic [3:0] dec_ctrl;
  logic       dec_ill;
  logic       rtype, r_add, r_sub, r_and, r_or;

  assign rtype = (id_alu_op == 2'b10);
  assign r_add = rtype && id_funct3 == 3'b000 && !id_funct7b5;
  assign r_sub = rtype && id_funct3 == 3'b000 && id_funct7b5;
  assign r_and = rtype && id_funct3 == 3'b111;
  assign r_or  = rtype && id_funct3 == 3'b110;

  // ALU control decode; anything undecodable runs as ADD and is flagged
  always_comb begin
    dec_ctrl = CtlAdd;
    dec_ill  = 1'b0;
    unique case (1'b1)
      id_alu_op == 2'b00: dec_ctrl = CtlAdd;
      id_alu_op == 2'b01: dec_ctrl = CtlSub;
      r_add:              dec_ctrl = CtlAdd;
      r_sub:              dec_ctrl = CtlSub;
      r_and:              dec_ctrl = CtlAnd;
      r_or:               dec_ctrl = CtlOr;
      default: begin
        dec_ctrl = CtlAdd;
        dec_ill  = 1'b1;
      end
    endcase
  end

  // Bubble and load images of the ID/EX register
  always_comb begin
    bubble      = '0;
    bubble.ctrl = CtlAdd;

    load           = '0;
    load.valid     = id_valid;
    load.ctrl      = dec_ctrl;
    load.reg_write = id_valid && id_reg_write && !dec_ill;
    load.rd        = id_rd;
    load.rs1       = id_rs1;
    load.rs2       = id_rs2;
    load.rs1_data  = id_rs1_data;
    load.rs2_data  = id_rs2_data;
    load.imm       = id_imm;
    load.alu_src   = id_alu_src;
    load.is_branch = id_valid && (id_alu_op == 2'b01);
    load.illegal   = id_valid && dec_ill;
  end

  // Next state: flush beats stall, stall holds, otherwise load
  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = bubble;
    end else if (!stall) begin
      ex_d = load;
    end
  end

  // ID/EX pipeline register with synchronous reset to a bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q <= bubble;
    end else begin
      ex_q <= ex_d;
    end
  end

  logic mem_a, wb_a, mem_b, wb_b;
  logic [XLEN-1:0] rs2_fwd;

  assign mem_a = exmem_reg_write && exmem_rd != '0 && exmem_rd == ex_q.rs1;
  assign wb_a  = memwb_reg_write && memwb_rd != '0 && memwb_rd == ex_q.rs1;
  assign mem_b = exmem_reg_write && exmem_rd != '0 && exmem_rd == ex_q.rs2;
  assign wb_b  = memwb_reg_write && memwb_rd != '0 && memwb_rd == ex_q.rs2;

  // Operand A forwarding; the younger EX/MEM result wins
  always_comb begin
    fwd_a = FwdReg;
    alu_a = ex_q.rs1_data;
    if (mem_a) begin
      fwd_a = FwdMem;
      alu_a = exmem_result;
    end else if (wb_a) begin
      fwd_a = FwdWb;
      alu_a = memwb_result;
    end
  end

  // Operand B forwarding; store data always sees forwarded rs2
  always_comb begin
    fwd_b   = FwdReg;
    rs2_fwd = ex_q.rs2_data;
    if (mem_b) begin
      fwd_b   = FwdMem;
      rs2_fwd = exmem_result;
    end else if (wb_b) begin
      fwd_b   = FwdWb;
      rs2_fwd = memwb_result;
    end
  end

  assign alu_b         = ex_q.alu_src ? ex_q.imm : rs2_fwd;
  assign ex_store_data = rs2_fwd;
  assign ex_valid      = ex_q.valid;
  assign alu_control   = ex_q.ctrl;
  assign ex_rd         = ex_q.rd;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_is_branch  = ex_q.is_branch;
  assign ex_illegal    = ex_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed plan items plus random traffic.
// Expected outputs come from a reference model and are checked by a monitor.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        reset, id_valid, stall, flush;
  logic [1:0]  id_alu_op;
  logic [2:0]  id_funct3;
  logic        id_funct7b5, id_alu_src, id_reg_write;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic        ex_valid, ex_reg_write, ex_is_branch, ex_illegal;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [3:0]  alu_control;
  logic [4:0]  ex_rd;
  logic [1:0]  fwd_a, fwd_b;

  alu_issue_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .stall(stall), .flush(flush),
    .id_alu_op(id_alu_op), .id_funct3(id_funct3),
    .id_funct7b5(id_funct7b5), .id_alu_src(id_alu_src),
    .id_reg_write(id_reg_write),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
    .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
    .memwb_result(memwb_result),
    .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b),
    .alu_control(alu_control), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_is_branch(ex_is_branch), .ex_illegal(ex_illegal),
    .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  always #5 clk = ~clk;

  // Instruction currently held in EX, as seen by the model
  typedef struct {
    bit v, rw, br, ill, src;
    bit [3:0] ctrl;
    bit [4:0] rd, rs1, rs2;
    bit [31:0] d1, d2, imm;
  } ins_t;

  typedef struct {
    bit v, rw, br, ill;
    bit [3:0] ctrl;
    bit [4:0] rd;
    bit [31:0] a, b, sd;
    bit [1:0] fa, fb;
  } exp_t;

  ins_t m;
  exp_t exq[$];
  int total = 0;
  int bad = 0;
  bit chk_on = 0;

  function automatic ins_t bubble_ins();
    ins_t b;
    b = '{default: '0};
    b.ctrl = 4'd2;
    return b;
  endfunction

  // Operation table: returns {illegal, code}
  function automatic bit [4:0] op_code(bit [1:0] op, bit [2:0] f3, bit b5);
    if (op == 0) return {1'b0, 4'd2};
    if (op == 1) return {1'b0, 4'd6};
    if (op == 3) return {1'b1, 4'd2};
    if (f3 == 0) return {1'b0, b5 ? 4'd6 : 4'd2};
    if (f3 == 7) return {1'b0, 4'd0};
    if (f3 == 6) return {1'b0, 4'd1};
    return {1'b1, 4'd2};
  endfunction

  // Which writeback value a register read sees right now
  task automatic source(input bit [4:0] r, input bit [31:0] regval,
                        output bit [31:0] v, output bit [1:0] sel);
    v = regval;
    sel = 2'b00;
    if (r != 0 && memwb_reg_write && memwb_rd == r) begin
      v = memwb_result;
      sel = 2'b01;
    end
    if (r != 0 && exmem_reg_write && exmem_rd == r) begin
      v = exmem_result;
      sel = 2'b10;
    end
  endtask

  task automatic push_exp();
    exp_t e;
    bit [31:0] b2;
    e.v = m.v; e.rw = m.rw; e.br = m.br; e.ill = m.ill;
    e.ctrl = m.ctrl; e.rd = m.rd;
    source(m.rs1, m.d1, e.a, e.fa);
    source(m.rs2, m.d2, b2, e.fb);
    e.sd = b2;
    e.b = m.src ? m.imm : b2;
    exq.push_back(e);
  endtask

  task automatic capture();
    bit [4:0] dc;
    if (reset || flush) begin
      m = bubble_ins();
    end else if (!stall) begin
      dc = op_code(id_alu_op, id_funct3, id_funct7b5);
      m.v = id_valid;
      m.ctrl = dc[3:0];
      m.ill = id_valid && dc[4];
      m.rw = id_valid && id_reg_write && !dc[4];
      m.br = id_valid && id_alu_op == 2'b01;
      m.rd = id_rd; m.rs1 = id_rs1; m.rs2 = id_rs2;
      m.d1 = id_rs1_data; m.d2 = id_rs2_data;
      m.imm = id_imm; m.src = id_alu_src;
    end
  endtask

  // One cycle: expectation for the current inputs, then the clock edge
  task automatic step();
    if (chk_on) push_exp();
    @(posedge clk);
    capture();
    #1;
  endtask

  task automatic cmp(input string nm, input bit [31:0] act,
                     input bit [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
    end
  endtask

  // Monitor: outputs are presented every cycle, compared mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (exq.size() > 0) begin
      e = exq.pop_front();
      cmp("ex_valid", 32'(ex_valid), 32'(e.v));
      cmp("alu_control", 32'(alu_control), 32'(e.ctrl));
      cmp("alu_a", alu_a, e.a);
      cmp("alu_b", alu_b, e.b);
      cmp("store_data", ex_store_data, e.sd);
      cmp("ex_rd", 32'(ex_rd), 32'(e.rd));
      cmp("reg_write", 32'(ex_reg_write), 32'(e.rw));
      cmp("is_branch", 32'(ex_is_branch), 32'(e.br));
      cmp("illegal", 32'(ex_illegal), 32'(e.ill));
      cmp("fwd_a", 32'(fwd_a), 32'(e.fa));
      cmp("fwd_b", 32'(fwd_b), 32'(e.fb));
    end
  end

  task automatic set_id(input bit v, input bit [1:0] op, input bit [2:0] f3,
                        input bit b5, input bit src, input bit rw,
                        input bit [4:0] r1, input bit [4:0] r2,
                        input bit [4:0] rd, input bit [31:0] d1,
                        input bit [31:0] d2, input bit [31:0] imm);
    id_valid = v; id_alu_op = op; id_funct3 = f3; id_funct7b5 = b5;
    id_alu_src = src; id_reg_write = rw;
    id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
  endtask

  task automatic set_wb(input bit mw, input bit [4:0] mr,
                        input bit [31:0] mv, input bit ww,
                        input bit [4:0] wr, input bit [31:0] wv);
    exmem_reg_write = mw; exmem_rd = mr; exmem_result = mv;
    memwb_reg_write = ww; memwb_rd = wr; memwb_result = wv;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit [2:0] f3s [3];
    f3s[0] = 3'd0; f3s[1] = 3'd6; f3s[2] = 3'd7;
    m = bubble_ins();
    reset = 1; stall = 0; flush = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_wb(0, 0, 0, 0, 0, 0);
    step();
    chk_on = 1;
    step();
    reset = 0;
    step();
    step();
    // R-type SUB, no hazards
    set_id(1, 2, 0, 1, 0, 1, 1, 2, 3, 9, 4, 0);
    step();
    // rs1=5 captured while both writeback ports target x5
    set_id(1, 2, 0, 0, 0, 1, 5, 6, 7, 1, 2, 0);
    set_wb(1, 5, 32'h11, 1, 5, 32'h22);
    step();
    stall = 1;
    step();
    set_wb(0, 5, 32'h11, 1, 5, 32'h22);
    step();
    stall = 0;
    // rs2=x0 must never forward
    set_id(1, 2, 0, 0, 0, 1, 3, 0, 4, 5, 32'h66, 0);
    set_wb(1, 0, 32'hFF, 1, 0, 32'hEE);
    step();
    step();
    // AND held across a 3-cycle stall, then stall+flush
    set_wb(0, 0, 0, 0, 0, 0);
    set_id(1, 2, 7, 0, 0, 1, 8, 9, 10, 32'hF0, 32'h3C, 0);
    step();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      set_id(1, 2, 6, 0, 1, 1, 11 + i, 12, 13, i, i + 1, 32'h77);
      step();
    end
    flush = 1;
    step();
    stall = 0; flush = 0;
    // illegal R-type funct3, then a branch compare
    set_id(1, 2, 2, 0, 0, 1, 1, 2, 3, 5, 6, 0);
    step();
    set_id(1, 1, 0, 0, 0, 0, 4, 5, 0, 7, 7, 0);
    step();
    set_id(0, 3, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    step();
    step();
    // Random traffic with a small register pool to provoke hazards
    for (int n = 0; n < 2000; n++) begin
      reset = ($urandom_range(0, 99) < 2);
      flush = ($urandom_range(0, 99) < 8);
      stall = ($urandom_range(0, 99) < 25);
      set_id($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
             $urandom_range(0, 1) ? f3s[$urandom_range(0, 2)]
                                  : 3'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom), $urandom, $urandom, $urandom);
      set_wb(1'($urandom), 5'($urandom_range(0, 3)), $urandom,
             1'($urandom), 5'($urandom_range(0, 3)), $urandom);
      step();
    end
    chk_on = 0;
    reset = 0; flush = 0; stall = 0;
    @(posedge clk);
    @(posedge clk);
    total++;
    if (exq.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", exq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
